data_to_axi_packer: RTL and testbench

Packs a stream of single elements (`data_i`, one `data_t` per beat) into full-width AXI4-Stream beats. It is the transmit-side counterpart of the AXI-to-data unpacker. Use it wherever per-element pipeline results must be returned to a wide AXI sink such as host DMA or a memory writer. A partial final beat is closed on `last`, and its unused lanes are marked invalid through `tkeep`.

---
 rtl/data_to_axi_packer_if.sv | 27 ++
 rtl/data_to_axi_packer.sv | 141 ++++++++++++++
 tb/tb_data_to_axi_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_to_axi_packer_if.sv
// Generic valid/ready stream bundle shared by the element input and the wide AXI4-Stream output.
//
// Parameters:
//   DataWidth - width of data (element width on the input, tdata width on the output)
//   KeepWidth - width of keep (1 on the input, DataWidth/8 byte strobes on the output)
// Signals:
//   data  - payload (tdata on the AXI side)
//   keep  - per-element / per-byte keep (tkeep on the AXI side)
//   last  - end of packet (tlast on the AXI side)
//   valid - source has a beat (tvalid)
//   ready - sink accepts the beat (tready)
// Modports:
//   m - source side (drives payload and valid, samples ready)
//   s - sink side (samples payload and valid, drives ready)
interface data_to_axi_packer_if #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned KeepWidth = 1
);
    logic [DataWidth-1:0] data;
    logic [KeepWidth-1:0] keep;
    logic                 last;
    logic                 valid;
    logic                 ready;

    modport m (output data, output keep, output last, output valid, input ready);
    modport s (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/data_to_axi_packer.sv
// Packs single elements into full-width AXI4-Stream beats. A beat closes when its last lane is
// filled or an element arrives with last set; lanes above the closing lane get tkeep = 0.
// Keep = 0 elements still occupy their lane (no compaction).
//
// Parameters:
//   data_t       - element type
//   AXI_WIDTH    - output tdata width in bits
//   DATA_WIDTH   - element width, multiple of 8, divides AXI_WIDTH
//   NUM_ELEMENTS - lanes per beat, >= 2
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   in    - element stream sink (data, keep[0:0], last, valid, ready)
//   out   - AXI4-Stream source (data=tdata, keep=tkeep, last=tlast, valid=tvalid, ready=tready)
// Configuration:
//   DATA_TO_AXI_ZERO_PAD_EN - when defined, tdata of unused and keep = 0 lanes is forced to 0;
//                             otherwise those lanes carry stale assembly contents.
module data_to_axi_packer #(
    parameter type         data_t       = logic [63:0],
    parameter int unsigned AXI_WIDTH    = 512,
    parameter int unsigned DATA_WIDTH   = $bits(data_t),
    parameter int unsigned NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    data_to_axi_packer_if.s in,
    data_to_axi_packer_if.m out
);
    localparam int unsigned LaneW     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int unsigned LaneBytes = DATA_WIDTH / 8;
    localparam int unsigned KeepW     = AXI_WIDTH / 8;
    localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_ELEMENTS - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_err_byte
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (AXI_WIDTH % DATA_WIDTH != 0) begin : g_err_div
        $error("DATA_WIDTH must divide AXI_WIDTH");
    end
    if (NUM_ELEMENTS < 2) begin : g_err_lanes
        $error("NUM_ELEMENTS must be at least 2");
    end

    logic [LaneW-1:0]        lane_q, lane_d;
    logic [AXI_WIDTH-1:0]    asm_data_q, asm_data_d;
    logic [NUM_ELEMENTS-1:0] asm_keep_q, asm_keep_d;
    logic [AXI_WIDTH-1:0]    tdata_q, tdata_d;
    logic [KeepW-1:0]        tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;

    logic                    closes;
    logic                    accept;
    logic [AXI_WIDTH-1:0]    merged_data;
    logic [NUM_ELEMENTS-1:0] merged_keep;
    logic [AXI_WIDTH-1:0]    beat_data;
    logic [KeepW-1:0]        beat_keep;

    // Only a closing element needs room in the output register; the rest always fit.
    assign closes   = (lane_q == LastLane) || in.last;
    assign in.ready = !closes || !tvalid_q || out.ready;
    assign accept   = in.valid && in.ready;

    // Assembly register with the offered element dropped into its lane.
    always_comb begin
        merged_data = asm_data_q;
        merged_keep = asm_keep_q;
        merged_data[lane_q*DATA_WIDTH +: DATA_WIDTH] = in.data;
        merged_keep[lane_q] = in.keep[0];
    end

    // Expand lane keep to byte strobes; lanes above the closing lane are never valid.
    always_comb begin
        beat_data = merged_data;
        beat_keep = '0;
        for (int unsigned l = 0; l < NUM_ELEMENTS; l++) begin
            beat_keep[l*LaneBytes +: LaneBytes] =
                {LaneBytes{(l <= 32'(lane_q)) && merged_keep[l]}};
`ifdef DATA_TO_AXI_ZERO_PAD_EN
            if (!((l <= 32'(lane_q)) && merged_keep[l])) begin
                beat_data[l*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
`endif
        end
    end

    always_comb begin
        lane_d     = lane_q;
        asm_data_d = asm_data_q;
        asm_keep_d = asm_keep_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;

        if (tvalid_q && out.ready) begin
            tvalid_d = 1'b0;
        end

        if (accept) begin
            asm_data_d = merged_data;
            if (closes) begin
                // A simultaneous drain is covered here: the new beat overrides the clear.
                lane_d     = '0;
                asm_keep_d = '0;
                tdata_d    = beat_data;
                tkeep_d    = beat_keep;
                tlast_d    = in.last;
                tvalid_d   = 1'b1;
            end else begin
                lane_d     = lane_q + 1'b1;
                asm_keep_d = merged_keep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q     <= '0;
            asm_data_q <= '0;
            asm_keep_q <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            asm_data_q <= asm_data_d;
            asm_keep_q <= asm_keep_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign out.data  = tdata_q;
    assign out.keep  = tkeep_q;
    assign out.last  = tlast_q;
    assign out.valid = tvalid_q;
endmodule

// File: tb/tb_data_to_axi_packer.sv
// Directed bench for data_to_axi_packer: 64-bit elements into 256-bit beats (4 lanes).
module tb_data_to_axi_packer;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 256;
    localparam int unsigned KW = AW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_to_axi_packer_if #(.DataWidth(DW), .KeepWidth(1))  in_if ();
    data_to_axi_packer_if #(.DataWidth(AW), .KeepWidth(KW)) out_if ();

    data_to_axi_packer #(
        .data_t    (logic [63:0]),
        .AXI_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_if),
        .out   (out_if)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW-1:0] bd[$];
    logic [KW-1:0] bk[$];
    logic          bl[$];
    int            bc[$];

    // Capture every beat that transfers on the output.
    always @(posedge clk) begin
        if (rst_n && out_if.valid && out_if.ready) begin
            bd.push_back(out_if.data);
            bk.push_back(out_if.keep);
            bl.push_back(out_if.last);
            bc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic clear_beats();
        bd.delete();
        bk.delete();
        bl.delete();
        bc.delete();
    endtask

    // Offer one element; returns the number of cycles until it was taken.
    task automatic send(input logic [63:0] d, input logic k, input logic l, output int tries);
        logic r;
        logic done;
        tries = 0;
        done = 1'b0;
        in_if.data  = d;
        in_if.keep  = k;
        in_if.last  = l;
        in_if.valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            r = in_if.ready;
            @(posedge clk);
            #1;
            tries++;
            if (r) begin
                done = 1'b1;
            end else if (tries >= 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: element %h not accepted after %0d cycles", d, tries);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle();
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (bd.size() < n && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        in_if.valid  = 1'b0;
        in_if.last   = 1'b0;
        in_if.keep   = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0) begin
            failures++; $display("FAIL reset_tvalid: got %b want 0", out_if.valid);
        end
        checks++;
        if (out_if.data !== '0) begin
            failures++; $display("FAIL reset_tdata: got %h want 0", out_if.data);
        end
        checks++;
        if (out_if.keep !== '0 || out_if.last !== 1'b0) begin
            failures++;
            $display("FAIL reset_tkeep_tlast: got %h/%b want 0/0", out_if.keep, out_if.last);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_if.ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: got %b want 1", in_if.ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_full_beats();
        int t;
        int total = 0;
        logic [AW-1:0] e0, e1;
        e0 = {64'd3, 64'd2, 64'd1, 64'd0};
        e1 = {64'd7, 64'd6, 64'd5, 64'd4};
        clear_beats();
        for (int i = 0; i < 8; i++) begin
            send(64'(i), 1'b1, (i == 7), t);
            total += t;
        end
        idle();
        wait_beats(2);
        checks++;
        if (total !== 8) begin
            failures++; $display("FAIL full_throughput: got %0d cycles want 8", total);
        end
        checks++;
        if (bd.size() !== 2) begin
            failures++; $display("FAIL full_beat_count: got %0d want 2", bd.size());
        end else begin
            checks++;
            if (bd[0] !== e0 || bk[0] !== 32'hFFFF_FFFF || bl[0] !== 1'b0) begin
                failures++;
                $display("FAIL full_beat0: got %h/%h/%b want %h/ffffffff/0", bd[0], bk[0], bl[0], e0);
            end
            checks++;
            if (bd[1] !== e1 || bk[1] !== 32'hFFFF_FFFF || bl[1] !== 1'b1) begin
                failures++;
                $display("FAIL full_beat1: got %h/%h/%b want %h/ffffffff/1", bd[1], bk[1], bl[1], e1);
            end
            checks++;
            if (bc[1] - bc[0] !== 4) begin
                failures++; $display("FAIL full_spacing: got %0d cycles want 4", bc[1] - bc[0]);
            end
        end
    endtask

    task automatic test_partial_last();
        int t;
        logic [127:0] lo;
        lo = {64'd5, 64'd4};
        clear_beats();
        for (int i = 0; i < 6; i++) begin
            send(64'(i), 1'b1, (i == 5), t);
        end
        idle();
        wait_beats(2);
        checks++;
        if (bd.size() !== 2) begin
            failures++; $display("FAIL partial_beat_count: got %0d want 2", bd.size());
        end else begin
            checks++;
            if (bd[1][127:0] !== lo || bk[1] !== 32'h0000_FFFF || bl[1] !== 1'b1) begin
                failures++;
                $display("FAIL partial_beat1: got %h/%h/%b want %h/0000ffff/1",
                         bd[1][127:0], bk[1], bl[1], lo);
            end
`ifdef DATA_TO_AXI_ZERO_PAD_EN
            checks++;
            if (bd[1][255:128] !== '0) begin
                failures++; $display("FAIL partial_pad: got %h want 0", bd[1][255:128]);
            end
`endif
        end
    endtask

    task automatic test_keep_zero();
        int t;
        clear_beats();
        for (int i = 0; i < 4; i++) begin
            send(64'(10 + i), (i != 2), (i == 3), t);
        end
        idle();
        wait_beats(1);
        checks++;
        if (bd.size() !== 1) begin
            failures++; $display("FAIL keep0_beat_count: got %0d want 1", bd.size());
        end else begin
            checks++;
            if (bk[0] !== 32'hFF00_FFFF || bl[0] !== 1'b1) begin
                failures++;
                $display("FAIL keep0_tkeep: got %h/%b want ff00ffff/1", bk[0], bl[0]);
            end
            checks++;
            if (bd[0][127:0] !== {64'd11, 64'd10} || bd[0][255:192] !== 64'd13) begin
                failures++; $display("FAIL keep0_data: got %h want lanes 13,x,11,10", bd[0]);
            end
`ifdef DATA_TO_AXI_ZERO_PAD_EN
            checks++;
            if (bd[0][191:128] !== '0) begin
                failures++; $display("FAIL keep0_pad: got %h want 0", bd[0][191:128]);
            end
`endif
        end
    endtask

    task automatic test_single();
        int t;
        clear_beats();
        send(64'hAB, 1'b1, 1'b1, t);
        idle();
        // Closing edge has just passed: the beat must already be presented.
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data[63:0] !== 64'hAB) begin
            failures++;
            $display("FAIL single_latency: got valid=%b data=%h want 1/ab",
                     out_if.valid, out_if.data[63:0]);
        end
        checks++;
        if (out_if.keep !== 32'h0000_00FF || out_if.last !== 1'b1) begin
            failures++;
            $display("FAIL single_keep_last: got %h/%b want 000000ff/1", out_if.keep, out_if.last);
        end
`ifdef DATA_TO_AXI_ZERO_PAD_EN
        checks++;
        if (out_if.data[255:64] !== '0) begin
            failures++; $display("FAIL single_pad: got %h want 0", out_if.data[255:64]);
        end
`endif
        wait_beats(1);
        checks++;
        if (bd.size() !== 1) begin
            failures++; $display("FAIL single_beat_count: got %0d want 1", bd.size());
        end
    endtask

    task automatic test_backpressure();
        int t;
        int fast = 0;
        int ready_bad = 0;
        int hold_bad = 0;
        logic [AW-1:0] e0, e1;
        e0 = {64'd3, 64'd2, 64'd1, 64'd0};
        e1 = {64'd7, 64'd6, 64'd5, 64'd4};
        clear_beats();
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(64'(i), 1'b1, 1'b0, t);
        end
        // Beat0 is now held; three non-closing elements must still flow.
        for (int i = 4; i < 7; i++) begin
            send(64'(i), 1'b1, 1'b0, t);
            fast += t;
        end
        checks++;
        if (fast !== 3) begin
            failures++; $display("FAIL bp_nonclosing: got %0d cycles want 3", fast);
        end
        in_if.data  = 64'd7;
        in_if.keep  = 1'b1;
        in_if.last  = 1'b1;
        in_if.valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (in_if.ready !== 1'b0) ready_bad++;
            if (out_if.valid !== 1'b1 || out_if.data !== e0 || out_if.last !== 1'b0) hold_bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (ready_bad !== 0) begin
            failures++; $display("FAIL bp_closing_stall: got %0d ready cycles want 0", ready_bad);
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++; $display("FAIL bp_beat0_stable: got %0d unstable cycles want 0", hold_bad);
        end
        out_if.ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_if.ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready: got %b want 1", in_if.ready);
        end
        @(posedge clk);
        #1;
        idle();
        wait_beats(2);
        checks++;
        if (bd.size() !== 2) begin
            failures++; $display("FAIL bp_beat_count: got %0d want 2", bd.size());
        end else begin
            checks++;
            if (bd[0] !== e0 || bd[1] !== e1 || bl[1] !== 1'b1) begin
                failures++;
                $display("FAIL bp_beats: got %h,%h/%b want %h,%h/1", bd[0], bd[1], bl[1], e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid_beat();
        int t;
        logic [AW-1:0] e;
        e = {64'hD, 64'hC, 64'hB, 64'hA};
        clear_beats();
        send(64'h11, 1'b1, 1'b0, t);
        send(64'h22, 1'b1, 1'b0, t);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state: got valid=%b ready=%b want 0/1", out_if.valid, in_if.ready);
        end
        @(posedge clk);
        #1;
        send(64'hA, 1'b1, 1'b0, t);
        send(64'hB, 1'b1, 1'b0, t);
        send(64'hC, 1'b1, 1'b0, t);
        send(64'hD, 1'b1, 1'b0, t);
        idle();
        wait_beats(1);
        checks++;
        if (bd.size() !== 1) begin
            failures++; $display("FAIL midrst_beat_count: got %0d want 1", bd.size());
        end else begin
            checks++;
            if (bd[0] !== e || bk[0] !== 32'hFFFF_FFFF || bl[0] !== 1'b0) begin
                failures++;
                $display("FAIL midrst_beat: got %h/%h/%b want %h/ffffffff/0", bd[0], bk[0], bl[0], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_full_beats();
        test_partial_last();
        test_keep_zero();
        test_single();
        test_backpressure();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
